// File: rtl/aes_uart_pkg.sv
// Shared types for the UART <-> AES-128 block sequencer.
//   ctrl_state_t : sequencer states
//   aes_block_t  : one 128-bit AES block
//   BLOCK_BYTES  : bytes per AES-128 block
package aes_uart_pkg;

  localparam int unsigned BLOCK_BYTES = 16;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [2:0] {
    S_RX,
    S_HAND,
    S_WAIT,
    S_TX_ISSUE,
    S_TX_BUSY,
    S_TX_GAP
  } ctrl_state_t;

endpackage

// File: rtl/uart_byte_shift128.sv
// 128-bit MSB-first byte shift register shared by the RX and TX paths.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   clear                : zero the whole register
//   load, load_data      : parallel load of a 128-bit block
//   shift_in, in_byte    : shift left one byte, new byte enters at [7:0]
//   shift_out            : shift left one byte, zeros enter at [7:0]
//   data                 : full register contents
//   out_byte             : current top byte [127:120]
// Priority: rst > clear > load > shift_in > shift_out.
module uart_byte_shift128 (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [127:0] load_data,
  input  logic         shift_in,
  input  logic [7:0]   in_byte,
  input  logic         shift_out,
  output logic [127:0] data,
  output logic [7:0]   out_byte
);

  logic [127:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (clear) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_data;
    end else if (shift_in) begin
      data_q <= {data_q[119:0], in_byte};
    end else if (shift_out) begin
      data_q <= {data_q[119:0], 8'h00};
    end
  end

  assign data     = data_q;
  assign out_byte = data_q[127:120];

endmodule

// File: rtl/uart_aes_block_ctrl.sv
// Sequencer between the UART byte interface and the AES-128 core.
// Collects 16 RX bytes into a block (byte 0 = MSB), offers it to the core, takes the result
// and serialises it back out MSB byte first. The UART link is half-duplex per block: RX
// bytes that arrive outside S_RX are dropped and flagged with overrun.
// Ports:
//   uart_clock, uart_reset        : clock, synchronous active-high reset
//   rx_data, rx_valid             : byte from uart_rx, captured on the rising edge of rx_valid
//   tx_ready, tx_start, tx_data   : uart_tx handshake; tx_data held until the next tx_start
//   blk_out_data/valid/ready      : assembled block to the AES core
//   blk_in_data/valid/ready       : result block from the AES core
//   busy                          : low only in S_RX with no bytes collected
//   overrun, timeout              : one-cycle event pulses
module uart_aes_block_ctrl #(
  parameter logic [4:0]  BLOCK_BYTES    = 5'd16,
  parameter logic [7:0]  TX_GAP_CYCLES  = 8'd4,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd0
) (
  input  logic         uart_clock,
  input  logic         uart_reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  input  logic         tx_ready,
  output logic         tx_start,
  output logic [7:0]   tx_data,
  output logic [127:0] blk_out_data,
  output logic         blk_out_valid,
  input  logic         blk_out_ready,
  input  logic [127:0] blk_in_data,
  input  logic         blk_in_valid,
  output logic         blk_in_ready,
  output logic         busy,
  output logic         overrun,
  output logic         timeout
);

  import aes_uart_pkg::*;

  localparam logic [3:0] LastByte = 4'(BLOCK_BYTES - 5'd1);

  ctrl_state_t state_q;
  logic        rx_valid_q;
  logic [3:0]  count_q;
  logic [3:0]  tx_idx_q;
  logic [7:0]  gap_q;
  logic [23:0] idle_q;
  logic        busy_wait_q;

  logic        rx_edge;
  logic [23:0] idle_inc;
  logic        timeout_hit;
  logic        gap_done;
  logic        busy_next;
  logic        sr_load;
  logic        sr_shift_in;
  logic [7:0]  sr_byte;

  always_comb begin
    rx_edge  = rx_valid & ~rx_valid_q;
    idle_inc = (idle_q == '1) ? idle_q : idle_q + 24'd1;
    // An rx_edge in the same cycle beats the timeout.
    timeout_hit = (TIMEOUT_CYCLES != 24'd0) && (state_q == S_RX) && !rx_edge &&
                  (count_q != 4'd0) && (idle_inc == TIMEOUT_CYCLES);
    gap_done    = (state_q == S_TX_GAP) && tx_ready && (gap_q >= TX_GAP_CYCLES);
    sr_load     = (state_q == S_WAIT) && blk_in_valid;
    sr_shift_in = (state_q == S_RX) && rx_edge;

    // busy is registered, so derive it from where the FSM is heading.
    unique case (state_q)
      S_RX:     busy_next = rx_edge || ((count_q != 4'd0) && !timeout_hit);
      S_TX_GAP: busy_next = !(gap_done && (tx_idx_q == LastByte));
      default:  busy_next = 1'b1;
    endcase
  end

  // One register serves both directions; the link is never receiving and sending at once.
  uart_byte_shift128 u_shift (
    .clk       (uart_clock),
    .rst       (uart_reset),
    .clear     (timeout_hit),
    .load      (sr_load),
    .load_data (blk_in_data),
    .shift_in  (sr_shift_in),
    .in_byte   (rx_data),
    .shift_out (gap_done),
    .data      (blk_out_data),
    .out_byte  (sr_byte)
  );

  always_ff @(posedge uart_clock) begin
    if (uart_reset) begin
      state_q       <= S_RX;
      // Reset high so a level held across reset is not mistaken for a new byte.
      rx_valid_q    <= 1'b1;
      count_q       <= '0;
      tx_idx_q      <= '0;
      gap_q         <= '0;
      idle_q        <= '0;
      busy_wait_q   <= 1'b0;
      tx_start      <= 1'b0;
      tx_data       <= '0;
      blk_out_valid <= 1'b0;
      blk_in_ready  <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      tx_start   <= 1'b0;
      overrun    <= rx_edge && (state_q != S_RX);
      timeout    <= timeout_hit;
      busy       <= busy_next;

      unique case (state_q)
        S_RX: begin
          if (rx_edge) begin
            idle_q <= '0;
            if (count_q == LastByte) begin
              count_q       <= '0;
              blk_out_valid <= 1'b1;
              state_q       <= S_HAND;
            end else begin
              count_q <= count_q + 4'd1;
            end
          end else if (count_q != 4'd0) begin
            if (timeout_hit) begin
              count_q <= '0;
              idle_q  <= '0;
            end else begin
              idle_q <= idle_inc;
            end
          end
        end

        S_HAND: begin
          if (blk_out_valid && blk_out_ready) begin
            blk_out_valid <= 1'b0;
            blk_in_ready  <= 1'b1;
            state_q       <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (blk_in_valid) begin
            blk_in_ready <= 1'b0;
            tx_idx_q     <= '0;
            state_q      <= S_TX_ISSUE;
          end
        end

        S_TX_ISSUE: begin
          if (tx_ready) begin
            tx_start    <= 1'b1;
            tx_data     <= sr_byte;
            busy_wait_q <= 1'b0;
            state_q     <= S_TX_BUSY;
          end
        end

        S_TX_BUSY: begin
          // A uart_tx that never drops ready is taken to have accepted after two cycles.
          if (!tx_ready || busy_wait_q) begin
            gap_q   <= '0;
            state_q <= S_TX_GAP;
          end else begin
            busy_wait_q <= 1'b1;
          end
        end

        S_TX_GAP: begin
          if (!tx_ready) begin
            gap_q <= '0;
          end else if (gap_done) begin
            if (tx_idx_q == LastByte) begin
              state_q <= S_RX;
            end else begin
              tx_idx_q <= tx_idx_q + 4'd1;
              state_q  <= S_TX_ISSUE;
            end
          end else begin
            gap_q <= gap_q + 8'd1;
          end
        end

        default: state_q <= S_RX;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_aes_block_ctrl.sv
// Self-checking bench for uart_aes_block_ctrl: a transaction-level model predicts the block
// handshakes, busy/overrun/timeout pulses and the TX byte stream; a uart_tx stand-in with
// random busy times drives tx_ready.
module tb_uart_aes_block_ctrl;

  localparam logic [7:0]  Gap = 8'd4;
  localparam logic [23:0] Tmo = 24'd100;

  logic         uart_clock = 1'b0;
  logic         uart_reset = 1'b1;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic         tx_ready = 1'b1;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic [127:0] blk_out_data;
  logic         blk_out_valid;
  logic         blk_out_ready = 1'b0;
  logic [127:0] blk_in_data = '0;
  logic         blk_in_valid = 1'b0;
  logic         blk_in_ready;
  logic         busy;
  logic         overrun;
  logic         timeout;

  always #5 uart_clock = ~uart_clock;

  uart_aes_block_ctrl #(
    .BLOCK_BYTES    (5'd16),
    .TX_GAP_CYCLES  (Gap),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .uart_clock    (uart_clock),
    .uart_reset    (uart_reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .tx_ready      (tx_ready),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .blk_out_data  (blk_out_data),
    .blk_out_valid (blk_out_valid),
    .blk_out_ready (blk_out_ready),
    .blk_in_data   (blk_in_data),
    .blk_in_valid  (blk_in_valid),
    .blk_in_ready  (blk_in_ready),
    .busy          (busy),
    .overrun       (overrun),
    .timeout       (timeout)
  );

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {MCollect, MOffer, MAwait, MTx, MTail} mphase_t;

  mphase_t    m_phase = MCollect;
  logic [7:0] m_bytes[$];
  logic [7:0] m_txq[$];
  logic [127:0] m_block = '0;
  int         m_idle = 0;
  logic       m_prev_rv = 1'b1;
  logic       m_live = 1'b0;
  logic       e_overrun = 1'b0;
  logic       e_timeout = 1'b0;
  logic       rx_rise;

  always @(posedge uart_clock) begin
    cycle++;
    e_overrun = 1'b0;
    e_timeout = 1'b0;
    if (uart_reset) begin
      m_live    = 1'b1;
      m_phase   = MCollect;
      m_bytes.delete();
      m_txq.delete();
      m_idle    = 0;
      m_prev_rv = 1'b1;
    end else begin
      rx_rise   = rx_valid && !m_prev_rv;
      m_prev_rv = rx_valid;
      if (rx_rise && m_phase != MCollect) e_overrun = 1'b1;
      case (m_phase)
        MCollect: begin
          if (rx_rise) begin
            m_bytes.push_back(rx_data);
            m_idle = 0;
            if (m_bytes.size() == 16) begin
              for (int k = 0; k < 16; k++) m_block[127 - 8*k -: 8] = m_bytes[k];
              m_bytes.delete();
              m_phase = MOffer;
            end
          end else if (m_bytes.size() > 0) begin
            m_idle++;
            if (m_idle == int'(Tmo)) begin
              m_bytes.delete();
              m_idle    = 0;
              e_timeout = 1'b1;
            end
          end
        end
        MOffer: if (blk_out_ready) m_phase = MAwait;
        MAwait: begin
          if (blk_in_valid) begin
            for (int k = 0; k < 16; k++) m_txq.push_back(blk_in_data[127 - 8*k -: 8]);
            m_phase = MTx;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- compare process + uart_tx stand-in ----------------
  int         ovr_seen = 0;
  int         tmo_seen = 0;
  int         tx_count = 0;
  int         hi_cnt = 1000;
  int         tx_left = 0;
  int         tail_deadline = 0;
  logic [7:0] tx_latched = '0;
  logic [7:0] tx_log[$];

  always @(negedge uart_clock) begin
    hi_cnt = tx_ready ? hi_cnt + 1 : 0;
    if (m_live) begin
      if (overrun === 1'b1) ovr_seen++;
      if (timeout === 1'b1) tmo_seen++;
      chk("overrun", overrun, e_overrun);
      chk("timeout", timeout, e_timeout);
      chk("blk_out_valid", blk_out_valid, m_phase == MOffer);
      if (m_phase == MOffer) chk("blk_out_data", blk_out_data, m_block);
      chk("blk_in_ready", blk_in_ready, m_phase == MAwait);
      if (m_phase != MTail) chk("busy", busy, !(m_phase == MCollect && m_bytes.size() == 0));
      if (m_phase == MTx && tx_start === 1'b1) begin
        chk("tx_byte", tx_data, m_txq[0]);
        void'(m_txq.pop_front());
        chk("tx_gap", hi_cnt >= int'(Gap), 1'b1);
        tx_count++;
        tx_latched = tx_data;
        tx_log.push_back(tx_data);
        if (m_txq.size() == 0) begin
          m_phase       = MTail;
          tail_deadline = cycle + 40 + int'(Gap);
        end
      end else begin
        chk("tx_start", tx_start, 1'b0);
      end
      if ((m_phase == MTx || m_phase == MTail) && !tx_ready) chk("tx_hold", tx_data, tx_latched);
      if (m_phase == MTail) begin
        if (busy === 1'b0) begin
          checks++;
          m_phase = MCollect;
        end else if (cycle > tail_deadline) begin
          checks++;
          failures++;
          $display("FAIL tx_return: busy=%b still high at cycle %0d, required 0", busy, cycle);
          m_phase = MCollect;
        end
      end
    end
    // uart_tx: drops ready after a start, stays busy for a random time.
    if (uart_reset) begin
      tx_ready = 1'b1;
      tx_left  = 0;
      hi_cnt   = 1000;
    end else if (tx_start === 1'b1) begin
      tx_ready = 1'b0;
      tx_left  = int'($urandom_range(2, 12));
    end else if (!tx_ready) begin
      tx_left--;
      if (tx_left <= 0) tx_ready = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge uart_clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(hi);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    tick(lo);
  endtask

  task automatic send_block(input logic [7:0] b[16], input bit fixed);
    for (int k = 0; k < 16; k++) begin
      if (fixed) send_byte(b[k], 3, 47);
      else send_byte(b[k], int'($urandom_range(1, 4)), int'($urandom_range(1, 40)));
    end
  endtask

  task automatic wait_phase(input mphase_t p, input int limit, input string name);
    int n;
    n = 0;
    while (m_phase != p && n < limit) begin
      tick(1);
      n++;
    end
    checks++;
    if (m_phase != p) begin
      failures++;
      $display("FAIL %s: phase %0d after %0d cycles, required %0d", name, m_phase, n, p);
    end
  endtask

  task automatic finish_block(input logic [127:0] result, input int ready_delay, input bit aa);
    int ov0;
    wait_phase(MOffer, 4, "offer");
    blk_out_ready = 1'b0;
    tick(ready_delay);
    blk_out_ready = 1'b1;
    tick(1);
    blk_out_ready = 1'b0;
    wait_phase(MAwait, 2, "await");
    if (aa) begin
      ov0 = ovr_seen;
      send_byte(8'hAA, 3, 4);
      chk("t4_overrun_once", ovr_seen - ov0, 1);
      chk("t4_still_waiting", blk_in_ready, 1'b1);
    end
    tick(int'($urandom_range(0, 5)));
    tx_log.delete();
    blk_in_data  = result;
    blk_in_valid = 1'b1;
    tick(1);
    blk_in_valid = 1'b0;
    blk_in_data  = {4{$urandom}};
    wait_phase(MCollect, 16 * 40 + 100, "tx_done");
  endtask

  logic [7:0] blk[16];
  int         tmo0;
  int         tx0;
  int         n;

  initial begin
    // Reset state.
    tick(3);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_blk_out_valid", blk_out_valid, 1'b0);
    chk("rst_blk_out_data", blk_out_data, 128'h0);
    chk("rst_blk_in_ready", blk_in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    uart_reset = 1'b0;
    tick(2);

    // 1-3: counting bytes, stalled handshake, known result stream.
    for (int k = 0; k < 16; k++) blk[k] = 8'(k);
    send_block(blk, 1'b1);
    wait_phase(MOffer, 4, "t1_offer");
    chk("t1_block", blk_out_data, 128'h000102030405060708090A0B0C0D0E0F);
    finish_block(128'h69C4E0D86A7B0430D8CDB78070B4C55A, 5, 1'b0);
    chk("t3_count", tx_log.size(), 16);
    chk("t3_first", tx_log[0], 8'h69);
    chk("t3_second", tx_log[1], 8'hC4);
    chk("t3_last", tx_log[15], 8'h5A);

    // 4: byte during S_WAIT, then a fresh block.
    for (int k = 0; k < 16; k++) blk[k] = 8'($urandom);
    send_block(blk, 1'b0);
    finish_block({4{$urandom}}, int'($urandom_range(0, 6)), 1'b1);

    // 5: partial block times out, next block assembles cleanly.
    tmo0 = tmo_seen;
    for (int k = 0; k < 3; k++) send_byte(8'($urandom), 2, 3);
    tick(110);
    chk("t5_timeout_once", tmo_seen - tmo0, 1);
    chk("t5_idle", busy, 1'b0);
    for (int k = 0; k < 16; k++) blk[k] = 8'(8'h10 + k);
    send_block(blk, 1'b0);
    wait_phase(MOffer, 4, "t5_offer");
    chk("t5_block", blk_out_data, 128'h101112131415161718191A1B1C1D1E1F);
    finish_block({4{$urandom}}, int'($urandom_range(0, 6)), 1'b0);

    // 6: reset during TX with rx_valid held across release.
    for (int k = 0; k < 16; k++) blk[k] = 8'($urandom);
    send_block(blk, 1'b0);
    wait_phase(MOffer, 4, "t6_offer");
    blk_out_ready = 1'b1;
    tick(1);
    blk_out_ready = 1'b0;
    blk_in_data   = {4{$urandom}};
    blk_in_valid  = 1'b1;
    tick(1);
    blk_in_valid  = 1'b0;
    tx0 = tx_count;
    n   = 0;
    while (tx_count - tx0 < 5 && n < 2000) begin
      tick(1);
      n++;
    end
    chk("t6_five_sent", tx_count - tx0, 5);
    rx_data    = 8'h3C;
    rx_valid   = 1'b1;
    tick(1);
    uart_reset = 1'b1;
    tick(1);
    uart_reset = 1'b0;
    tick(4);
    chk("t6_busy", busy, 1'b0);
    chk("t6_no_start", tx_start, 1'b0);
    chk("t6_no_valid", blk_out_valid, 1'b0);
    rx_valid = 1'b0;
    tick(3);

    // Random blocks.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 16; k++) blk[k] = 8'($urandom);
      send_block(blk, 1'b0);
      finish_block({4{$urandom}}, int'($urandom_range(0, 6)), r == 1);
    end

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    failures++;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finished", cycle);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
